// File: rtl/chan_snapshot_pkg.sv
// Shared types and helpers for the channel snapshot packer.
package chan_snapshot_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Number of bytes needed to carry one channel of 'width' bits.
    function automatic int bytes_per_ch(input int width);
        return (width + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/chan_snapshot_packer_if.sv
// Read port and byte stream of the channel snapshot packer.
//
// Stream handshake: the packer (master) raises byte_valid and holds byte_out
// and byte_last stable until the consumer (slave) samples byte_ready=1 on a
// rising iclk edge with byte_valid=1; that edge transfers exactly one byte.
// byte_valid never drops before its byte has transferred.
interface chan_snapshot_packer_if #(
    parameter int ADDR_W = 8
);
    import chan_snapshot_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic [BYTE_W-1:0] rd_data;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic              byte_last;

    modport master (
        input  rd_addr, byte_ready,
        output rd_data, byte_out, byte_valid, byte_last
    );

    modport slave (
        output rd_addr, byte_ready,
        input  rd_data, byte_out, byte_valid, byte_last
    );

endinterface

// File: rtl/chan_snapshot_packer_snap_byte_mux.sv
// Selects byte[idx] from a flat multi-channel snapshot; each channel is padded
// with zeros up to a whole number of bytes. Out-of-range indices return 0.
module snap_byte_mux
    import chan_snapshot_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int CH_WIDTH = 50,
    parameter int IDX_W    = 8
) (
    input  logic [NUM_CH*CH_WIDTH-1:0] snap,
    input  logic [IDX_W-1:0]           idx,
    output logic [BYTE_W-1:0]          byte_sel
);

    localparam int BPC   = bytes_per_ch(CH_WIDTH);
    localparam int TOTAL = NUM_CH * BPC;

    logic [TOTAL*BYTE_W-1:0] padded;

    // Re-lay channels on byte boundaries; bits above CH_WIDTH stay zero.
    always_comb begin
        padded = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            padded[k*BPC*BYTE_W +: CH_WIDTH] = snap[k*CH_WIDTH +: CH_WIDTH];
        end
    end

    // Compare-and-select keeps every part-select in range for any idx.
    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < TOTAL; i++) begin
            if (int'(idx) == i) begin
                byte_sel = padded[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/chan_snapshot_packer.sv
// Channel snapshot packer: captures NUM_CH channels atomically and exposes the
// snapshot as byte-addressed registered reads and as a valid/ready stream.
// Optional build macro CHAN_SNAPSHOT_CHECKSUM_EN appends an XOR checksum byte
// to the stream and makes it readable at BASE_ADDR+TOTAL.
module chan_snapshot_packer
    import chan_snapshot_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int CH_WIDTH  = 50,
    parameter int BASE_ADDR = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                       iclk,
    input  logic                       rstn,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic                       capture,
    input  logic                       stream_start,
    input  logic                       clr_overrun,
    output logic                       busy,
    output logic                       snap_valid,
    output logic                       overrun,
    output state_t                     dbg_state,
    chan_snapshot_packer_if.master     bus
);

    localparam int BPC   = bytes_per_ch(CH_WIDTH);
    localparam int TOTAL = NUM_CH * BPC;
`ifdef CHAN_SNAPSHOT_CHECKSUM_EN
    localparam int STREAM_LEN = TOTAL + 1;
`else
    localparam int STREAM_LEN = TOTAL;
`endif
    localparam int IDX_W = $clog2(STREAM_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STREAM_LEN - 1);

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [NUM_CH*CH_WIDTH-1:0] snapshot;
    logic                       valid_q;
    logic [BYTE_W-1:0]          stream_mux_byte;
    logic [BYTE_W-1:0]          stream_byte;
    logic [BYTE_W-1:0]          rd_mux_byte;
    logic [BYTE_W-1:0]          rd_next;
    logic [ADDR_W-1:0]          rd_off;
    logic                       rd_in_range;

    snap_byte_mux #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .IDX_W(IDX_W)) u_stream_mux (
        .snap     (snapshot),
        .idx      (idx),
        .byte_sel (stream_mux_byte)
    );

    snap_byte_mux #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .IDX_W(ADDR_W)) u_rd_mux (
        .snap     (snapshot),
        .idx      (rd_off),
        .byte_sel (rd_mux_byte)
    );

    assign rd_in_range = (int'(bus.rd_addr) >= BASE_ADDR) &&
                         (int'(bus.rd_addr) <  BASE_ADDR + TOTAL);
    assign rd_off      = ADDR_W'(int'(bus.rd_addr) - BASE_ADDR);

`ifdef CHAN_SNAPSHOT_CHECKSUM_EN
    logic [BPC*BYTE_W-1:0] ch_fold;
    logic [BYTE_W-1:0]     checksum;

    // XOR of all snapshot bytes: fold the channels first, then the bytes.
    always_comb begin
        ch_fold = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_fold[CH_WIDTH-1:0] ^= snapshot[k*CH_WIDTH +: CH_WIDTH];
        end
        checksum = '0;
        for (int b = 0; b < BPC; b++) begin
            checksum ^= ch_fold[b*BYTE_W +: BYTE_W];
        end
    end

    assign stream_byte = (idx == IDX_W'(TOTAL)) ? checksum : stream_mux_byte;
    assign rd_next     = rd_in_range ? rd_mux_byte :
                         (int'(bus.rd_addr) == BASE_ADDR + TOTAL) ? checksum : '0;
`else
    assign stream_byte = stream_mux_byte;
    assign rd_next     = rd_in_range ? rd_mux_byte : '0;
`endif

    // Snapshot capture, overrun flag and IDLE/STREAM sequencing.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            idx        <= '0;
            snapshot   <= '0;
            snap_valid <= 1'b0;
            busy       <= 1'b0;
            valid_q    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // A new drop wins over a same-edge clear.
            overrun <= (overrun && !clr_overrun) || (state == STREAM && capture);
            case (state)
                IDLE: begin
                    if (capture) begin
                        snapshot   <= ch_data;
                        snap_valid <= 1'b1;
                    end
                    if (stream_start && (snap_valid || capture)) begin
                        state   <= STREAM;
                        idx     <= '0;
                        busy    <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.byte_ready) begin
                        if (idx == LAST_IDX) begin
                            state   <= IDLE;
                            idx     <= '0;
                            busy    <= 1'b0;
                            valid_q <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered random read, refreshed every cycle regardless of state.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_next;
        end
    end

    assign bus.byte_valid = valid_q;
    assign bus.byte_out   = valid_q ? stream_byte : '0;
    assign bus.byte_last  = valid_q && (idx == LAST_IDX);
    assign dbg_state      = state;

endmodule

// File: tb/tb_chan_snapshot_packer.sv
// Self-checking bench for chan_snapshot_packer (NUM_CH=8, CH_WIDTH=50, BASE_ADDR=4).
module tb_chan_snapshot_packer;
    import chan_snapshot_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int CH_WIDTH  = 50;
    localparam int BASE_ADDR = 4;
    localparam int BPC       = 7;
    localparam int TOTAL     = 56;
`ifdef CHAN_SNAPSHOT_CHECKSUM_EN
    localparam int SLEN = 57;
`else
    localparam int SLEN = 56;
`endif

    // ---------------- clock / reset ----------------
    logic iclk = 1'b0;
    logic rstn = 1'b0;
    always #5 iclk = ~iclk;

    logic [NUM_CH*CH_WIDTH-1:0] ch_data = '0;
    logic   capture = 1'b0, stream_start = 1'b0, clr_overrun = 1'b0;
    logic   busy, snap_valid, overrun;
    state_t dbg_state;

    chan_snapshot_packer_if #(.ADDR_W(8)) bus ();

    chan_snapshot_packer #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .BASE_ADDR(BASE_ADDR), .ADDR_W(8)
    ) dut (
        .iclk(iclk), .rstn(rstn), .ch_data(ch_data), .capture(capture),
        .stream_start(stream_start), .clr_overrun(clr_overrun), .busy(busy),
        .snap_valid(snap_valid), .overrun(overrun), .dbg_state(dbg_state), .bus(bus)
    );

    // ---------------- model / scoreboard ----------------
    logic [CH_WIDTH-1:0] model_ch [NUM_CH];
    logic [8:0]          exp_q[$];
    int checks = 0;
    int errors = 0;
    int stream_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] snap_byte(int i);
        logic [63:0] v;
        v = 64'(model_ch[i / BPC]);
        return v[8*(i % BPC) +: 8];
    endfunction

    function automatic logic [7:0] model_byte(int i);
        logic [7:0] x;
        if (i < TOTAL) return snap_byte(i);
        x = 8'h00;
        for (int j = 0; j < TOTAL; j++) x ^= snap_byte(j);
        return x;
    endfunction

    // Expected read value at BASE_ADDR+TOTAL (checksum only when enabled).
    function automatic logic [7:0] exp_after_end();
        return (SLEN > TOTAL) ? model_byte(TOTAL) : 8'h00;
    endfunction

    task automatic push_stream();
        for (int i = 0; i < SLEN; i++) exp_q.push_back({(i == SLEN - 1), model_byte(i)});
    endtask

    // ---------------- monitor ----------------
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_byte   = '0;
    logic       expect_idle = 1'b0;
    logic [8:0] exp_e;

    always @(negedge iclk) begin
        if (!rstn) begin
            prev_stall  = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                check("busy_drop", {30'd0, busy, bus.byte_valid}, 32'd0);
                expect_idle = 1'b0;
            end
            if (prev_stall) check("stall_hold", {24'd0, bus.byte_out}, {24'd0, prev_byte});
            prev_stall = bus.byte_valid && !bus.byte_ready;
            prev_byte  = bus.byte_out;
            if (bus.byte_valid && bus.byte_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.byte_out);
                end else begin
                    exp_e = exp_q.pop_front();
                    check($sformatf("stream_byte[%0d]", stream_cnt),
                          {23'd0, bus.byte_last, bus.byte_out}, {23'd0, exp_e});
                    stream_cnt++;
                    if (exp_e[8]) expect_idle = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic load_and_capture(input logic [CH_WIDTH-1:0] vals [NUM_CH], input logic with_start);
        for (int k = 0; k < NUM_CH; k++) begin
            model_ch[k] = vals[k];
            ch_data[k*CH_WIDTH +: CH_WIDTH] = vals[k];
        end
        capture = 1'b1;
        stream_start = with_start;
        tick();
        capture = 1'b0;
        stream_start = 1'b0;
    endtask

    task automatic start_stream();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic [7:0] exp, input string name);
        bus.rd_addr = 8'(addr);
        @(posedge iclk);
        @(negedge iclk);
        check(name, {24'd0, bus.rd_data}, {24'd0, exp});
        tick();
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(negedge iclk);
            #2;
            if (exp_q.size() == 0 && !busy) begin
                tick();
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, %0d bytes still expected", name, exp_q.size());
        exp_q.delete();
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [CH_WIDTH-1:0] pat_a [NUM_CH] = '{
        50'h3_0102_0304_0506, 50'h2_AAAA_5555_1234, 50'h0_FFFF_0000_FFFF, 50'h3_FFFF_FFFF_FFFF,
        50'h0_0000_0000_0000, 50'h1_2345_6789_ABCD, 50'h2_0000_0000_0001, 50'h2_8000_0000_0080};
    logic [CH_WIDTH-1:0] pat_b [NUM_CH] = '{
        50'h1_1111_2222_3333, 50'h0_0F0F_F0F0_0F0F, 50'h3_DEAD_BEEF_CAFE, 50'h0_0000_0000_00FF,
        50'h2_4444_5555_6666, 50'h1_0000_0001_0000, 50'h3_7777_8888_9999, 50'h0_0123_4567_89AB};
    logic [CH_WIDTH-1:0] pat_one [NUM_CH] = '{default: 50'h1};
    logic [3:0] ready_pat = 4'b1001;   // applied LSB first: 1,0,0,1
    int target;

    initial begin
        bus.rd_addr    = '0;
        bus.byte_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) model_ch[k] = '0;
        repeat (3) tick();
        @(negedge iclk);
        check("reset_outputs", {24'd0, bus.rd_data}, 32'd0);
        check("reset_flags", {26'd0, bus.byte_out == 0, bus.byte_valid, bus.byte_last, busy, snap_valid, overrun}, 32'h20);
        check("reset_state", {31'd0, dbg_state}, {31'd0, IDLE});
        @(posedge iclk);
        #1 rstn = 1'b1;
        tick();

        // stream_start with no snapshot is ignored
        start_stream();
        @(negedge iclk);
        check("start_without_snap", {30'd0, busy, bus.byte_valid}, 32'd0);
        tick();

        // capture and random reads
        load_and_capture(pat_a, 1'b0);
        check("snap_valid_set", {31'd0, snap_valid}, 32'd1);
        do_read(4, 8'h06, "rd_ch0_b0");
        do_read(5, 8'h05, "rd_ch0_b1");
        do_read(6, 8'h04, "rd_ch0_b2");
        do_read(7, 8'h03, "rd_ch0_b3");
        do_read(8, 8'h02, "rd_ch0_b4");
        do_read(9, 8'h01, "rd_ch0_b5");
        do_read(10, 8'h03, "rd_ch0_b6_pad");
        do_read(3, 8'h00, "rd_below_base");
        do_read(59, 8'h02, "rd_last_byte");
        do_read(60, exp_after_end(), "rd_after_end");
        do_read(255, 8'h00, "rd_far");

        // live data changes do not disturb the snapshot
        ch_data = ~ch_data;
        do_read(4, 8'h06, "rd_hold_b0");
        do_read(10, 8'h03, "rd_hold_b6");

        // full-rate stream
        push_stream();
        start_stream();
        wait_done(200, "stream_full");

        // backpressure 1,0,0,1
        push_stream();
        start_stream();
        for (int n = 0; n < 1000; n++) begin
            bus.byte_ready = ready_pat[n % 4];
            tick();
            if (!busy && exp_q.size() == 0) break;
        end
        bus.byte_ready = 1'b1;
        wait_done(50, "stream_backpressure");

        // capture during stream is dropped and flagged
        push_stream();
        start_stream();
        repeat (3) tick();
        ch_data = '1;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        wait_done(200, "stream_overrun");
        check("overrun_set", {31'd0, overrun}, 32'd1);
        do_read(4, 8'h06, "rd_after_overrun");
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("overrun_clr", {31'd0, overrun}, 32'd0);

        // new overrun beats a same-edge clear
        push_stream();
        start_stream();
        repeat (2) tick();
        capture = 1'b1;
        clr_overrun = 1'b1;
        tick();
        capture = 1'b0;
        clr_overrun = 1'b0;
        check("overrun_set_wins", {31'd0, overrun}, 32'd1);
        wait_done(200, "stream_set_wins");
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;

        // same-edge capture + start streams the new data
        for (int k = 0; k < NUM_CH; k++) model_ch[k] = pat_b[k];
        push_stream();
        load_and_capture(pat_b, 1'b1);
        wait_done(200, "stream_same_edge");
        do_read(6, 8'h22, "rd_patb_b2");

        // reset in the middle of a stream
        push_stream();
        target = stream_cnt + 20;
        start_stream();
        for (int n = 0; n < 200; n++) begin
            @(negedge iclk);
            #2;
            if (stream_cnt >= target) break;
        end
        check("reached_byte20", {31'd0, stream_cnt >= target}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midreset_flags", {26'd0, bus.byte_out == 0, bus.byte_valid, bus.byte_last, busy, snap_valid, overrun}, 32'h20);
        check("midreset_rd", {24'd0, bus.rd_data}, 32'd0);
        exp_q.delete();
        @(posedge iclk);
        #1 rstn = 1'b1;
        tick();
        for (int k = 0; k < NUM_CH; k++) model_ch[k] = pat_a[k];
        push_stream();
        load_and_capture(pat_a, 1'b1);
        wait_done(200, "stream_after_reset");

        // all channels = 1: checksum byte (if present) is 0
        load_and_capture(pat_one, 1'b0);
        push_stream();
        start_stream();
        wait_done(200, "stream_all_ones");
        do_read(60, 8'h00, "rd_after_end_ones");
        do_read(4, 8'h01, "rd_ones_b0");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a wait above is ever unbounded.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/chan_snapshot_packer.md
Name: chan_snapshot_packer

Overview:
- Parametrised successor to the fixed 8x50-bit channel-to-byte splitter that feeds the SPI register map.
- On a capture pulse, atomically snapshots NUM_CH channels of CH_WIDTH bits each.
- The snapshot is then presented two ways: byte-addressed random reads for the SPI register file, and a valid/ready byte stream for bulk readout.
- Sits between the analog channel registers and the SPI/POCI logic, in the iclk domain.

Parameters:
- NUM_CH, 8, number of channels.
- CH_WIDTH, 50, bits per channel.
- BASE_ADDR, 4, register address of byte 0 of channel 0.
- ADDR_W, 8, width of the register read address.

Ports:
- iclk  in  1  system clock.
- rstn  in  1  reset.
- ch_data  in  NUM_CH*CH_WIDTH  live channel data; channel k occupies bits [k*CH_WIDTH +: CH_WIDTH].
- capture  in  1  snapshot request, sampled on iclk.
- stream_start  in  1  begin streaming the snapshot.
- rd_addr  in  ADDR_W  register read address.
- rd_data  out  8  registered read data.
- byte_out  out  8  stream data.
- byte_valid  out  1  stream valid.
- byte_ready  in  1  stream ready.
- byte_last  out  1  marks the final stream byte.
- busy  out  1  high while in STREAM.
- snap_valid  out  1  a snapshot is held.
- overrun  out  1  sticky flag: a capture was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Clock and reset: one clock, iclk; reset rstn is asynchronous, active-low.
- Reset values: rd_data=0, byte_out=0, byte_valid=0, byte_last=0, busy=0, snap_valid=0, overrun=0, snapshot=0, state=IDLE, index=0.
- Byte layout:
  - BPC = ceil(CH_WIDTH/8); TOTAL = NUM_CH*BPC.
  - Linear index i = ch*BPC + b; byte b holds channel bits [8b+7:8b].
  - Bits at or above CH_WIDTH read as 0. Example: the top byte of a 50-bit channel carries only bits 49:48 in [1:0]; [7:2]=0.
- Capture:
  - In IDLE, capture=1 loads all channels into the snapshot on that edge and sets snap_valid=1.
  - In STREAM, capture is ignored, the snapshot is unchanged, and overrun is set to 1 on the next edge.
  - overrun stays set until clr_overrun=1; if clr_overrun and a new overrun occur on the same edge, set wins.
- Random read:
  - rd_data is registered, 1-cycle latency, and updates every cycle in every state.
  - rd_data = snapshot byte (rd_addr - BASE_ADDR) when BASE_ADDR <= rd_addr < BASE_ADDR+TOTAL; otherwise 0x00.
- State machine, IDLE -> STREAM:
  - Transition on stream_start=1 with snap_valid=1, or with capture=1 on the same edge. A same-edge capture is accepted first and the stream carries the new data.
  - stream_start while snap_valid=0 and capture=0 is ignored.
  - On entry, index=0.
- In STREAM:
  - busy=1 and byte_valid=1 continuously.
  - byte_out = snapshot byte[index], driven combinationally from index.
  - byte_last = (index == TOTAL-1).
  - On byte_valid && byte_ready, index increments. Holding byte_ready=0 holds index and data stable indefinitely.
- STREAM -> IDLE: on the handshake of the byte_last byte. Then byte_valid=0, busy=0, index=0; snap_valid stays 1, so the same snapshot can be re-streamed.
- stream_start while in STREAM is ignored.
- Mid-operation reset: rstn low at any time forces the reset values immediately; a partial stream is discarded.

Optional Feature:
- Macro: CHAN_SNAPSHOT_CHECKSUM_EN.
- When defined:
  - One extra byte, the XOR of all TOTAL snapshot bytes, is appended at stream index TOTAL.
  - byte_last moves to that byte.
  - The checksum is also readable at rd_addr = BASE_ADDR+TOTAL.
- When undefined:
  - The stream is exactly TOTAL bytes.
  - rd_addr = BASE_ADDR+TOTAL reads 0x00.

Decomposition:
- Package chan_snapshot_pkg:
  - function bytes_per_ch(width);
  - state_t enum {IDLE, STREAM};
  - localparam BYTE_W=8.
- One sub-module, snap_byte_mux: selects byte[idx] from the flat snapshot with zero padding. It has two instances, one for the stream index and one for the read address.

Test Plan (NUM_CH=8, CH_WIDTH=50, BASE_ADDR=4; TOTAL=56):
- Capture with ch0 = 50'h3_0102_0304_0506 -> rd_addr 4..10 return 06,05,04,03,02,01,03, each one cycle after its address; rd_addr 3 and 60 return 00.
- Change ch_data after capture, without recapturing -> rd_data is unchanged.
- stream_start with byte_ready=1 -> 56 consecutive bytes in index order; byte_last only on byte 56; busy drops the cycle after.
- Backpressure: byte_ready toggles 1,0,0,1 -> byte_out/index hold during the 0 cycles; no bytes lost or repeated.
- capture during STREAM -> stream data unchanged; overrun=1; clr_overrun -> overrun=0.
- stream_start before any capture -> stays IDLE.
- rstn low at byte 20 -> all outputs are 0 immediately; a new capture plus stream_start restarts at index 0.
- With CHAN_SNAPSHOT_CHECKSUM_EN and all channels = 0x1 -> 57 bytes are streamed; the last byte is 0x00 (eight 0x01 bytes XOR to 0); rd_addr 60 returns 0x00.
